// File: rtl/bit_serializer.sv
// bit_serializer: loads a WIDTH-bit word and shifts it out MSB first on
// ser_out, one bit per CLK cycle, with ser_valid marking frame bits.
// Words can be accepted back-to-back with no idle gap between frames.
// frames_sent counts completed frames modulo 256.
//
// Optional feature: define SER_PARITY_EN to append one even-parity bit
// (XOR of the data bits) after the LSB. The frame is then WIDTH+1 bits, and
// din_ready and the frame count move to the parity bit cycle.
//
// Reset is synchronous and active-high (rst). din_ready is low while rst is
// high, so no word can be accepted during reset.

module bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic [7:0]       frames_sent
);

`ifdef SER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
`ifdef SER_PARITY_EN
  // Bit index at which ser_out holds the data LSB; the parity bit follows.
  localparam logic [CNT_W-1:0] LSB_IDX = CNT_W'(WIDTH - 1);
`endif

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-2:0] rem;       // data bits still to be shifted out
  logic [CNT_W-1:0] bit_cnt;   // index of the bit currently on ser_out
  logic             last_bit;
  logic             xfer;
`ifdef SER_PARITY_EN
  logic             parity;    // even parity of the word being sent
`endif

  // The last frame bit is on ser_out this cycle.
  assign last_bit = (state == SHIFT) && (bit_cnt == LAST_IDX);

  // Ready comes from registered state only, so it never depends on din_valid.
  // NOTE: an always_comb that assigns its output on every path infers plain
  // gates; leaving a path unassigned would infer a latch.
  always_comb begin
    din_ready = !rst && ((state == IDLE) || last_bit);
  end

  assign xfer = din_valid && din_ready;

  // Frame FSM: load on transfer, shift each cycle, count finished frames.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge CLK) begin
    if (rst) begin
      // The shift register and counter are cleared too, so an aborted frame
      // leaves nothing behind to emit.
      state       <= IDLE;
      rem         <= '0;
      bit_cnt     <= '0;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      busy        <= 1'b0;
      frames_sent <= 8'd0;
`ifdef SER_PARITY_EN
      parity      <= 1'b0;
`endif
    end else begin
      if (last_bit) begin
        frames_sent <= frames_sent + 8'd1;
      end

      if (xfer) begin
        // The new word's MSB goes out on the next cycle. This also covers the
        // back-to-back case where the old frame's last bit is on the wire.
        state     <= SHIFT;
        rem       <= din[WIDTH-2:0];
        bit_cnt   <= '0;
        ser_out   <= din[WIDTH-1];
        ser_valid <= 1'b1;
        busy      <= 1'b1;
`ifdef SER_PARITY_EN
        parity    <= ^din;
`endif
      end else if (last_bit) begin
        // Frame done and no new word: drive zeros between frames.
        state     <= IDLE;
        rem       <= '0;
        bit_cnt   <= '0;
        ser_out   <= 1'b0;
        ser_valid <= 1'b0;
        busy      <= 1'b0;
      end else if (state == SHIFT) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
        rem     <= rem << 1;
`ifdef SER_PARITY_EN
        if (bit_cnt == LSB_IDX) begin
          ser_out <= parity;
        end else begin
          ser_out <= rem[WIDTH-2];
        end
`else
        ser_out <= rem[WIDTH-2];
`endif
      end
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed testbench for bit_serializer (WIDTH=8). Compile with
// +define+SER_PARITY_EN to check the parity-frame build. A behavioural
// 1101 sequence detector watches ser_out, the way the downstream block does.

module tb_bit_serializer;

  localparam int WIDTH = 8;
`ifdef SER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  logic             CLK = 1'b0;
  logic             rst = 1'b1;
  logic             din_valid = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             din_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic [7:0]       frames_sent;

  int n_checks = 0;
  int n_pass   = 0;

  bit_serializer #(.WIDTH(WIDTH)) dut (
    .CLK        (CLK),
    .rst        (rst),
    .din_valid  (din_valid),
    .din        (din),
    .din_ready  (din_ready),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .busy       (busy),
    .frames_sent(frames_sent)
  );

  always #5 CLK = ~CLK;

  // Overlapping 1101 detector on the raw serial line.
  logic [2:0] det_hist = '0;
  int         det_pulses = 0;
  always @(posedge CLK) begin
    if (rst) begin
      det_hist <= '0;
    end else begin
      if ({det_hist, ser_out} == 4'b1101) det_pulses <= det_pulses + 1;
      det_hist <= {det_hist[1:0], ser_out};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expected bit j of a frame carrying word w: MSB first, then parity.
  function automatic logic exp_bit(input logic [WIDTH-1:0] w, input int j);
    if (j < WIDTH) return w[WIDTH-1-j];
    return ^w;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    din_valid = 1'b0;
    tick();
    tick();
    check("rst_ser_valid", 32'(ser_valid), 32'd0);
    check("rst_ser_out", 32'(ser_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frames", 32'(frames_sent), 32'd0);
    check("rst_din_ready", 32'(din_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("idle_din_ready", 32'(din_ready), 32'd1);
  endtask

  // One isolated frame: transfer, check every bit, then the idle state.
  task automatic send_frame(input logic [WIDTH-1:0] w);
    din = w;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int j = 0; j < FRAME; j++) begin
      check("frame_bit", 32'(ser_out), 32'(exp_bit(w, j)));
      check("frame_valid", 32'(ser_valid), 32'd1);
      check("frame_busy", 32'(busy), 32'd1);
      check("frame_ready", 32'(din_ready), 32'(j == FRAME - 1));
      tick();
    end
    check("post_valid", 32'(ser_valid), 32'd0);
    check("post_ser_out", 32'(ser_out), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int det0;
    logic [WIDTH-1:0] w;

    // Reset and a single 8'hD0 frame.
    do_reset();
    det0 = det_pulses;
    send_frame(8'hD0);
    check("d0_frames", 32'(frames_sent), 32'd1);
    check("d0_detector", 32'(det_pulses - det0), 32'd1);

    // 8'h0F frame (parity bit 0 in the parity build).
    send_frame(8'h0F);
    check("0f_frames", 32'(frames_sent), 32'd2);

    // Held din_valid: 8'hB4 then 8'h0F back-to-back, no double acceptance.
    do_reset();
    din = 8'hB4;
    din_valid = 1'b1;
    tick();
    din = 8'h0F;
    for (int j = 0; j < 2 * FRAME; j++) begin
      w = (j < FRAME) ? 8'hB4 : 8'h0F;
      check("b2b_bit", 32'(ser_out), 32'(exp_bit(w, j % FRAME)));
      check("b2b_valid", 32'(ser_valid), 32'd1);
      check("b2b_ready", 32'(din_ready), 32'((j % FRAME) == FRAME - 1));
      tick();
      if (j == FRAME - 1) din_valid = 1'b0;
    end
    check("b2b_idle_valid", 32'(ser_valid), 32'd0);
    check("b2b_frames", 32'(frames_sent), 32'd2);

    // Reset in the middle of an 8'hFF frame aborts it.
    do_reset();
    din = 8'hFF;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check("abort_bit", 32'(ser_out), 32'd1);
      if (j < 2) tick();
    end
    rst = 1'b1;
    din_valid = 1'b1;
    #1;
    check("abort_ready_in_rst", 32'(din_ready), 32'd0);
    tick();
    check("abort_valid", 32'(ser_valid), 32'd0);
    check("abort_ser_out", 32'(ser_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_frames", 32'(frames_sent), 32'd0);
    rst = 1'b0;
    din_valid = 1'b0;
    tick();
    tick();
    check("abort_no_tail", 32'(ser_valid), 32'd0);
    check("abort_frames_after", 32'(frames_sent), 32'd0);

    // 257 back-to-back frames: counter wraps to 0, then reads 1.
    do_reset();
    det0 = det_pulses;
    din = 8'hD0;
    din_valid = 1'b1;
    tick();
    repeat (FRAME * 256 - 1) tick();
    check("wrap_pre_frames", 32'(frames_sent), 32'd255);
    check("wrap_pre_ready", 32'(din_ready), 32'd1);
    tick();
    check("wrap_frames", 32'(frames_sent), 32'd0);
    check("wrap_next_valid", 32'(ser_valid), 32'd1);
    check("wrap_next_msb", 32'(ser_out), 32'd1);
    din_valid = 1'b0;
    repeat (FRAME) tick();
    check("wrap_257_frames", 32'(frames_sent), 32'd1);
    check("wrap_257_idle", 32'(ser_valid), 32'd0);
    check("wrap_detector", 32'(det_pulses - det0), 32'd257);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
